// File: rtl/ia_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : ia_buffer_reader
// Brief    : Read-side sequencer for the MMA input-activation SRAM buffer.
//            Turns a (base, len, stride) command into single-word SRAM reads
//            and returns the words as a valid/ready stream with a last flag.
// Revision : 1.0 - initial release
// ============================================================================
module ia_buffer_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic                  abort,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  localparam logic [ADDR_WIDTH:0] c_len_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH:0]   r_issue_rem;
  logic [ADDR_WIDTH:0]   r_pop_rem;
  logic                  r_inflight;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic                  w_accept;
  logic                  w_active;
  logic                  w_abort;
  logic [c_cnt_w:0]      w_occ;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_pop_last;

  // FIFO pointer advance with wrap at FIFO_DEPTH (need not be a power of two)
  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Words in flight toward the consumer: FIFO contents plus the read whose data
  // lands this cycle. Capping this at FIFO_DEPTH makes overflow impossible.
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_active   = (r_state != c_st_idle);
  assign w_abort    = abort && w_active;
  assign w_occ      = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_issue    = (r_state == c_st_run) && (r_issue_rem != '0) &&
                      (w_occ < (c_cnt_w + 1)'(FIFO_DEPTH));
  assign w_push     = r_inflight;
  assign w_pop      = (r_count != '0) && out_ready;
  assign w_pop_last = w_pop && (r_pop_rem == c_len_one);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // Next-state logic; abort wins over everything while a command is active
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept && (cmd_len != '0)) w_next_state = c_st_run;
      end
      c_st_run: begin
        if (abort)                                     w_next_state = c_st_idle;
        else if (w_pop_last)                           w_next_state = c_st_idle;
        else if (w_issue && (r_issue_rem == c_len_one)) w_next_state = c_st_drain;
      end
      c_st_drain: begin
        if (abort || w_pop_last) w_next_state = c_st_idle;
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // State-derived outputs and the stream view of the FIFO head
  always_comb begin
    cmd_ready    = (r_state == c_st_idle);
    busy         = w_active;
    sram_rd_en   = w_issue;
    sram_rd_addr = r_addr;
    out_valid    = (r_count != '0);
    out_data     = r_fifo[r_rd_ptr];
    out_last     = (r_count != '0) && (r_pop_rem == c_len_one);
    done         = r_done;
  end

  // Command bookkeeping: address walk and issue/pop countdowns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_stride    <= '0;
      r_issue_rem <= '0;
      r_pop_rem   <= '0;
    end else if (w_accept) begin
      r_addr      <= cmd_base;
      r_stride    <= cmd_stride;
      r_issue_rem <= cmd_len;
      r_pop_rem   <= cmd_len;
    end else begin
      if (w_issue) begin
        r_addr      <= r_addr + r_stride;
        r_issue_rem <= r_issue_rem - 1'b1;
      end
      if (w_pop && !w_abort) r_pop_rem <= r_pop_rem - 1'b1;
    end
  end

  // Read-latency tracker and completion pulse; abort drops the pending read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue && !w_abort;
      r_done     <= (w_accept && (cmd_len == '0)) || (w_pop_last && !w_abort);
    end
  end

  // Output FIFO; simultaneous push and pop are both honoured, abort flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= sram_rd_data;
        r_wr_ptr         <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
